// File: rtl/dbu_ctrl_pkg.sv
// Shared constants for the debug-unit controller: status field offsets, display selects, run FSM states.
// Pure declarations, no logic, no latency, no backpressure.
package dbu_ctrl_pkg;

    localparam int SGN_LSB    = 224;
    localparam int NPC_LSB    = 192;
    localparam int PC_LSB     = 160;
    localparam int IR_LSB     = 128;
    localparam int RD0_LSB    = 96;
    localparam int RD1_LSB    = 64;
    localparam int ALUOUT_LSB = 32;
    localparam int MDR_LSB    = 0;

    typedef enum logic [2:0] {
        SEL_MEM_RF = 3'd0,
        SEL_NPC    = 3'd1,
        SEL_PC     = 3'd2,
        SEL_IR     = 3'd3,
        SEL_RD0    = 3'd4,
        SEL_RD1    = 3'd5,
        SEL_ALU    = 3'd6,
        SEL_MDR    = 3'd7
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_CONT = 2'd2
    } run_state_e;

endpackage

// File: rtl/dbu_debounce.sv
// 2-FF synchroniser + debouncer with rise pulse; level follows input 2+DEB_CYCLES cycles later.
// Free-running, no backpressure; rise pulse is one cycle wide on the debounced level.
module dbu_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic             r_sync0;
    logic             r_sync1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_din;
            r_sync1 <= r_sync0;
        end
    end

    // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
            if (r_sync1 != r_level) begin
                if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_level <= r_sync1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/dbu_ctrl.sv
// Debug-unit controller: run/step FSM, scan address counter, registered display and signal LEDs.
// run follows debounced pulses by 1 cycle, display/LEDs are 1 cycle behind inputs; no backpressure.
module dbu_ctrl
    import dbu_ctrl_pkg::*;
#(
    parameter int STATUS_W   = 247,
    parameter int SIGNAL_W   = 23,
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 8,
    parameter int DEB_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                succ,
    input  logic                step,
    input  logic [2:0]          sel,
    input  logic                m_rf,
    input  logic                inc,
    input  logic                dec,
    input  logic [STATUS_W-1:0] status,
    input  logic [WIDTH-1:0]    m_data,
    input  logic [WIDTH-1:0]    rf_data,
    output logic                run,
    output logic [ADDR_W-1:0]   m_rf_addr,
    output logic [WIDTH-1:0]    disp_data,
    output logic [SIGNAL_W-1:0] sgn_led
);

    logic w_succ_lvl;
    logic w_succ_rise;
    logic w_step_lvl;
    logic w_step_rise;
    logic w_inc_lvl;
    logic w_inc_rise;
    logic w_dec_lvl;
    logic w_dec_rise;

    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_succ (
        .clk(clk), .rst(rst), .i_din(succ), .o_level(w_succ_lvl), .o_rise(w_succ_rise)
    );
    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .rst(rst), .i_din(step), .o_level(w_step_lvl), .o_rise(w_step_rise)
    );
    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst(rst), .i_din(inc), .o_level(w_inc_lvl), .o_rise(w_inc_rise)
    );
    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk(clk), .rst(rst), .i_din(dec), .o_level(w_dec_lvl), .o_rise(w_dec_rise)
    );

    // sel and m_rf are level selects: synchronised only, never debounced.
    logic [2:0] r_sel_s0;
    logic [2:0] r_sel_s1;
    logic       r_mrf_s0;
    logic       r_mrf_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_s0 <= '0;
            r_sel_s1 <= '0;
            r_mrf_s0 <= 1'b0;
            r_mrf_s1 <= 1'b0;
        end else begin
            r_sel_s0 <= sel;
            r_sel_s1 <= r_sel_s0;
            r_mrf_s0 <= m_rf;
            r_mrf_s1 <= r_mrf_s0;
        end
    end

    run_state_e r_state;
    run_state_e w_state_nxt;
    logic       w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // run is decoded from the state register only, so it never glitches on input changes.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_succ_lvl) begin
                    w_state_nxt = ST_CONT;
                end else if (w_step_rise) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                w_run       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_CONT: begin
                w_run = 1'b1;
                if (!w_succ_lvl) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign run = w_run;

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else begin
            case ({w_inc_rise, w_dec_rise})
                2'b10:   r_addr <= r_addr + ADDR_W'(1);
                2'b01:   r_addr <= r_addr - ADDR_W'(1);
                default: r_addr <= r_addr;
            endcase
        end
    end

    assign m_rf_addr = r_addr;

    logic [WIDTH-1:0] w_disp_nxt;

    always_comb begin
        w_disp_nxt = '0;
        case (sel_e'(r_sel_s1))
            SEL_MEM_RF: w_disp_nxt = r_mrf_s1 ? m_data : rf_data;
            SEL_NPC:    w_disp_nxt = status[NPC_LSB +: WIDTH];
            SEL_PC:     w_disp_nxt = status[PC_LSB +: WIDTH];
            SEL_IR:     w_disp_nxt = status[IR_LSB +: WIDTH];
            SEL_RD0:    w_disp_nxt = status[RD0_LSB +: WIDTH];
            SEL_RD1:    w_disp_nxt = status[RD1_LSB +: WIDTH];
            SEL_ALU:    w_disp_nxt = status[ALUOUT_LSB +: WIDTH];
            SEL_MDR:    w_disp_nxt = status[MDR_LSB +: WIDTH];
            default:    w_disp_nxt = '0;
        endcase
    end

    logic [WIDTH-1:0]    r_disp;
    logic [SIGNAL_W-1:0] r_sgn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= '0;
            r_sgn  <= '0;
        end else begin
            r_disp <= w_disp_nxt;
            r_sgn  <= status[STATUS_W-1 -: SIGNAL_W];
        end
    end

    assign disp_data = r_disp;
    assign sgn_led   = r_sgn;

endmodule

// File: tb/tb_dbu_ctrl.sv
// Directed bench for dbu_ctrl with a short debounce window (4 cycles).
module tb_dbu_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         succ;
    logic         step;
    logic [2:0]   sel;
    logic         m_rf;
    logic         inc;
    logic         dec;
    logic [246:0] status;
    logic [31:0]  m_data;
    logic [31:0]  rf_data;
    logic         run;
    logic [7:0]   m_rf_addr;
    logic [31:0]  disp_data;
    logic [22:0]  sgn_led;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbu_ctrl #(
        .STATUS_W(247), .SIGNAL_W(23), .WIDTH(32), .ADDR_W(8), .DEB_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .succ(succ), .step(step), .sel(sel), .m_rf(m_rf),
        .inc(inc), .dec(dec), .status(status), .m_data(m_data), .rf_data(rf_data),
        .run(run), .m_rf_addr(m_rf_addr), .disp_data(disp_data), .sgn_led(sgn_led)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit so samples and drives sit away from the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_run(input int n, output int c);
        c = 0;
        repeat (n) begin
            tick(1);
            c += int'(run);
        end
    endtask

    initial begin
        int          nrun;
        logic [31:0] exp_sel [8];

        rst     = 1'b1;
        succ    = 1'b0;
        step    = 1'b0;
        sel     = 3'd0;
        m_rf    = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        m_data  = 32'h1234_5678;
        rf_data = 32'hCAFE_F00D;
        status  = '0;
        status[246:224] = 23'h5_A5A5;
        status[223:192] = 32'h0000_0104;
        status[191:160] = 32'h0000_0010;
        status[159:128] = 32'h00A0_0093;
        status[127:96]  = 32'h1111_1111;
        status[95:64]   = 32'h2222_2222;
        status[63:32]   = 32'h3333_3333;
        status[31:0]    = 32'h4444_4444;

        // Reset state
        tick(3);
        check("rst_run",  {31'd0, run}, 32'd0);
        check("rst_addr", {24'd0, m_rf_addr}, 32'd0);
        check("rst_disp", disp_data, 32'd0);
        check("rst_sgn",  {9'd0, sgn_led}, 32'd0);
        rst = 1'b0;

        tick(1);
        check("sgn_led", {9'd0, sgn_led}, 32'h0005_A5A5);
        check("disp_rf", disp_data, 32'hCAFE_F00D);

        // Display: sel passes 2 sync flops, then the output register
        sel = 3'd2;
        tick(2);
        check("disp_pc_early", disp_data, 32'hCAFE_F00D);
        tick(1);
        check("disp_pc", disp_data, 32'h0000_0010);
        status[191:160] = 32'h0000_0020;
        status[246:224] = 23'h7F_FFFF;
        tick(1);
        check("disp_pc_follow", disp_data, 32'h0000_0020);
        check("sgn_led_follow", {9'd0, sgn_led}, 32'h007F_FFFF);

        exp_sel[1] = 32'h0000_0104;
        exp_sel[2] = 32'h0000_0020;
        exp_sel[3] = 32'h00A0_0093;
        exp_sel[4] = 32'h1111_1111;
        exp_sel[5] = 32'h2222_2222;
        exp_sel[6] = 32'h3333_3333;
        exp_sel[7] = 32'h4444_4444;
        for (int s = 1; s < 8; s++) begin
            sel = 3'(s);
            tick(3);
            check($sformatf("disp_sel%0d", s), disp_data, exp_sel[s]);
        end

        sel    = 3'd0;
        m_rf   = 1'b1;
        m_data = 32'hDEAD_BEEF;
        tick(3);
        check("disp_mem", disp_data, 32'hDEAD_BEEF);

        // Step press held 20 cycles: run exactly at cycle 7
        step = 1'b1;
        tick(6);
        check("step_pre", {31'd0, run}, 32'd0);
        tick(1);
        check("step_run", {31'd0, run}, 32'd1);
        count_run(13, nrun);
        check("step_hold_norepeat", 32'(nrun), 32'd0);
        step = 1'b0;
        tick(10);

        // 3-cycle glitch is shorter than the debounce window
        step = 1'b1;
        tick(3);
        step = 1'b0;
        count_run(20, nrun);
        check("step_glitch", 32'(nrun), 32'd0);

        // Continuous run
        succ = 1'b1;
        tick(6);
        check("cont_pre", {31'd0, run}, 32'd0);
        tick(1);
        check("cont_start", {31'd0, run}, 32'd1);
        step = 1'b1;
        count_run(20, nrun);
        check("cont_step_ignored", 32'(nrun), 32'd20);
        step = 1'b0;
        tick(10);
        succ = 1'b0;
        tick(6);
        check("cont_stop_pre", {31'd0, run}, 32'd1);
        tick(1);
        check("cont_stop", {31'd0, run}, 32'd0);
        count_run(10, nrun);
        check("cont_idle_after", 32'(nrun), 32'd0);

        // Address counter wrap and simultaneous inc/dec
        dec = 1'b1;
        tick(6);
        check("dec_pre", {24'd0, m_rf_addr}, 32'h00);
        tick(1);
        check("dec_wrap", {24'd0, m_rf_addr}, 32'hFF);
        tick(5);
        check("dec_hold", {24'd0, m_rf_addr}, 32'hFF);
        dec = 1'b0;
        tick(8);
        inc = 1'b1;
        tick(7);
        check("inc_wrap", {24'd0, m_rf_addr}, 32'h00);
        inc = 1'b0;
        tick(8);
        inc = 1'b1;
        dec = 1'b1;
        tick(10);
        check("inc_dec_same", {24'd0, m_rf_addr}, 32'h00);
        inc = 1'b0;
        dec = 1'b0;
        tick(8);
        inc = 1'b1;
        tick(7);
        check("inc_one", {24'd0, m_rf_addr}, 32'h01);
        inc = 1'b0;
        tick(8);

        // Asynchronous reset in the middle of continuous run
        succ = 1'b1;
        tick(10);
        check("cont_before_rst", {31'd0, run}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_run",  {31'd0, run}, 32'd0);
        check("arst_addr", {24'd0, m_rf_addr}, 32'd0);
        check("arst_disp", disp_data, 32'd0);
        check("arst_sgn",  {9'd0, sgn_led}, 32'd0);
        succ = 1'b0;
        tick(2);
        rst = 1'b0;
        count_run(10, nrun);
        check("idle_after_rst", 32'(nrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbu_ctrl.md
# dbu_ctrl

Debug-unit controller sitting directly downstream of the multicycle CPU core. It drives the core's `run` enable for single-step or continuous execution and scans memory/register-file contents through `m_rf_addr`. It also selects one 32-bit field of the core's `status` bus (or the `m_data`/`rf_data` readback) for the board display path. Push buttons and switches are synchronised and debounced inside the block.

## Interface
- `STATUS_W`, default 247: core status bus width.
- `SIGNAL_W`, default 23: control-signal field width at top of `status`.
- `WIDTH`, default 32: datapath word width.
- `ADDR_W`, default 8: `m_rf_addr` width.
- `DEB_CYCLES`, default 100000: cycles an input must stay stable to be accepted (≥2).
- Reset `rst`: asynchronous, active-high. Clock `clk`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `succ` in 1: switch; high selects continuous run.
- `step` in 1: button; each press runs one CPU cycle.
- `sel` in 3: display select.
- `m_rf` in 1: 1 shows memory (`m_data`), 0 shows register file (`rf_data`), when `sel`=0.
- `inc` in 1: button; advance `m_rf_addr`.
- `dec` in 1: button; retreat `m_rf_addr`.
- `status` in STATUS_W: core status.
- `m_data` in WIDTH: memory readback at `m_rf_addr`.
- `rf_data` in WIDTH: register readback at `m_rf_addr[4:0]`.
- `run` out 1: CPU enable.
- `m_rf_addr` out ADDR_W: scan address.
- `disp_data` out WIDTH: value for the 7-segment driver.
- `sgn_led` out SIGNAL_W: control signals, `status[STATUS_W-1 -: SIGNAL_W]`, registered.

## Operation
- **Input conditioning.**
  - All button/switch inputs (`succ`, `step`, `inc`, `dec`, `m_rf`, `sel`) pass a 2-FF synchroniser.
  - `succ`, `step`, `inc` and `dec` then pass a debouncer. The debounced level changes only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles.
  - A rising-edge pulse (1 cycle) is generated on the debounced `step`, `inc` and `dec`.
- **Run FSM** (states IDLE, STEP, CONT):
  - IDLE: if debounced `succ`=1, go to CONT; else if `step` pulse, go to STEP; else stay. `run`=0.
  - STEP: `run`=1 for exactly one cycle, then return to IDLE.
  - CONT: `run`=1 every cycle. When debounced `succ`=0, go to IDLE. `step` pulses are ignored.
  - `succ` has priority over a simultaneous `step` pulse.
- **Address counter.**
  - An `inc` pulse gives +1 and a `dec` pulse gives −1, modulo 2^ADDR_W: 0xFF+1 wraps to 0x00, and 0x00−1 wraps to 0xFF.
  - Simultaneous `inc` and `dec` pulses leave the address unchanged.
- **Display mux** (registered):
  - `sel`=0 shows `m_rf ? m_data : rf_data`.
  - `sel`=1 shows next_PC `status[223:192]`.
  - `sel`=2 shows PC `[191:160]`.
  - `sel`=3 shows instruction `[159:128]`.
  - `sel`=4 shows rd0 `[127:96]`.
  - `sel`=5 shows rd1 `[95:64]`.
  - `sel`=6 shows alu_out `[63:32]`.
  - `sel`=7 shows mdr `[31:0]`.

## Timing
- Reset values:
  - `run`=0, `m_rf_addr`=0, `disp_data`=0, `sgn_led`=0, FSM=IDLE.
  - All synchroniser and debounce state is cleared to 0.
- Reset mid-operation (any state, including CONT or STEP): outputs return to their reset values immediately (asynchronous).
- Input latency (raw input change to debounced level): 2 synchroniser cycles + DEB_CYCLES.
- Step press: `run` is high exactly 1 cycle, in the cycle after the edge pulse. A held button gives no repeat; a new press requires release and re-debounce.
- Address: `m_rf_addr` updates in the cycle after the `inc`/`dec` pulse. The new `disp_data` value (`sel`=0) appears 1 cycle after the readback changes.
- `disp_data` and `sgn_led` follow `status`/`sel` with 1-cycle latency. `sel` and `m_rf` pass the synchroniser only, so they take 2 extra cycles but are not debounced.
- Glitches shorter than DEB_CYCLES produce no pulse.

## Structure
- Shared package/header holds:
  - Status field offsets (SGN_LSB=224, NPC_LSB=192, PC_LSB=160, IR_LSB=128, RD0_LSB=96, RD1_LSB=64, ALUOUT_LSB=32, MDR_LSB=0).
  - `sel` encodings.
  - FSM state codes.
- One sub-module, `dbu_debounce`: synchroniser, stable counter, debounced level and rise pulse. It is instantiated four times.

## Test plan
- **Reset:** assert `rst` mid-CONT → `run`, `m_rf_addr` and `disp_data` go to 0 the same cycle; FSM=IDLE after release.
- **Step** (DEB_CYCLES=4): press `step` for 20 cycles → exactly one `run` cycle. A 3-cycle glitch → 0 `run` cycles.
- **Continuous:** `succ`=1 → `run` high continuously from 2+4+1 cycles after the change. Pressing `step` in CONT has no effect. `succ`=0 → `run` low after the debounce delay.
- **Address wrap:** `dec` from 0 → 0xFF. `inc` from 0xFF → 0x00. Simultaneous `inc`+`dec` → unchanged.
- **Display:** `status` with PC=0x0000_0010 and `sel`=2 → `disp_data`=0x10 after sync + 1 cycle. `sel`=0, `m_rf`=1, `m_data`=0xDEADBEEF → `disp_data`=0xDEADBEEF. `sgn_led` equals `status[246:224]`.
